// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the write-back port arbiter.
// Select encoding, queue entry layout and the starvation counter width live here.
package wb_arb_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 3;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT = 4;

    // Wide enough for any starvation limit in 1..15.
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_PIPE,
        SEL_FIFO,
        SEL_BYPASS
    } wb_sel_e;

    // Queue entry layout at the default widths.
    typedef struct packed {
        logic                  live;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular buffer of auxiliary results with kill-by-address and a per-register
// live mask; only the live bits and pointers are reset, payload storage is not.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 push,
    input  logic                 push_live,
    input  logic [ADDR_W-1:0]    push_addr,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 pop,
    input  logic                 kill,
    input  logic [ADDR_W-1:0]    kill_addr,
    output logic                 head_live,
    output logic [ADDR_W-1:0]    head_addr,
    output logic [DATA_W-1:0]    head_data,
    output logic                 full,
    output logic                 empty,
    output logic [2**ADDR_W-1:0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DEPTH-1:0]  live;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_live = live[rd_ptr] && !empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Later assignments win: a fresh push into a slot overrides kill/pop clears.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && addr_mem[i] == kill_addr)    live[i] <= 1'b0;
                if (pop_ok && PTR_W'(i) == rd_ptr)       live[i] <= 1'b0;
                if (push_ok && PTR_W'(i) == wr_ptr)      live[i] <= push_live;
            end
        end
    end

    // NOTE: payload storage has no reset; validity is carried entirely by the
    // reset live bits and count, so clearing the data would only cost logic.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: always_comb outputs get a default first so no path infers a latch.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) pending[addr_mem[i]] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, then queued aux results,
// with stale-result kill and a starvation stall. Macro WB_ARB_BYPASS_EN enables aux bypass.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pipe_write_back,
    input  logic [ADDR_W-1:0]    i_pipe_write_addr,
    input  logic [DATA_W-1:0]    i_pipe_write_data,
    input  logic                 i_aux_valid,
    output logic                 o_aux_ready,
    input  logic [ADDR_W-1:0]    i_aux_addr,
    input  logic [DATA_W-1:0]    i_aux_data,
    output logic                 o_rf_we,
    output logic [ADDR_W-1:0]    o_rf_addr,
    output logic [DATA_W-1:0]    o_rf_data,
    output logic                 o_stall,
    output logic [2**ADDR_W-1:0] o_pending
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    wb_sel_e                 sel;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    head_live;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic                    aux_accept;
    logic                    push;
    logic                    push_live;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] starve_cnt_next;

    assign o_aux_ready = !fifo_full;
    assign aux_accept  = i_aux_valid && !fifo_full;

    always_comb begin
        sel = SEL_NONE;
        if (i_pipe_write_back) begin
            sel = SEL_PIPE;
        end else if (!fifo_empty) begin
            sel = SEL_FIFO;
`ifdef WB_ARB_BYPASS_EN
        end else if (i_aux_valid) begin
            sel = SEL_BYPASS;
`endif
        end
    end

    // Aux results are older than a concurrent pipe write, so a matching one is born dead.
    assign push      = aux_accept && (sel != SEL_BYPASS);
    assign push_live = !(i_pipe_write_back && i_aux_addr == i_pipe_write_addr);

    wb_arb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (push),
        .push_live (push_live),
        .push_addr (i_aux_addr),
        .push_data (i_aux_data),
        .pop       (sel == SEL_FIFO),
        .kill      (i_pipe_write_back),
        .kill_addr (i_pipe_write_addr),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .pending   (o_pending)
    );

    // Counts cycles a live head loses to the pipe; saturates if the pipe ignores the stall.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (fifo_empty || sel == SEL_FIFO) begin
            starve_cnt_next = '0;
        end else if (head_live && sel == SEL_PIPE && starve_cnt != LIMIT) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rf_we    <= 1'b0;
            o_rf_addr  <= '0;
            o_rf_data  <= '0;
            o_stall    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_next;
            o_stall    <= (starve_cnt_next == LIMIT);
            unique case (sel)
                SEL_PIPE: begin
                    o_rf_we   <= 1'b1;
                    o_rf_addr <= i_pipe_write_addr;
                    o_rf_data <= i_pipe_write_data;
                end
                SEL_FIFO: begin
                    o_rf_we   <= head_live;
                    o_rf_addr <= head_addr;
                    o_rf_data <= head_data;
                end
                SEL_BYPASS: begin
                    o_rf_we   <= 1'b1;
                    o_rf_addr <= i_aux_addr;
                    o_rf_data <= i_aux_data;
                end
                default: begin
                    o_rf_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter at default parameters.
// Aux-latency expectations follow WB_ARB_BYPASS_EN.
module tb_wb_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pipe_write_back = 1'b0;
    logic [2:0]  i_pipe_write_addr = '0;
    logic [15:0] i_pipe_write_data = '0;
    logic        i_aux_valid = 1'b0;
    logic        o_aux_ready;
    logic [2:0]  i_aux_addr = '0;
    logic [15:0] i_aux_data = '0;
    logic        o_rf_we;
    logic [2:0]  o_rf_addr;
    logic [15:0] o_rf_data;
    logic        o_stall;
    logic [7:0]  o_pending;

    int total = 0;
    int bad = 0;

    wb_port_arbiter dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_pipe_write_back (i_pipe_write_back),
        .i_pipe_write_addr (i_pipe_write_addr),
        .i_pipe_write_data (i_pipe_write_data),
        .i_aux_valid       (i_aux_valid),
        .o_aux_ready       (o_aux_ready),
        .i_aux_addr        (i_aux_addr),
        .i_aux_data        (i_aux_data),
        .o_rf_we           (o_rf_we),
        .o_rf_addr         (o_rf_addr),
        .o_rf_data         (o_rf_data),
        .o_stall           (o_stall),
        .o_pending         (o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pipe(input logic en, input logic [2:0] a, input logic [15:0] d);
        i_pipe_write_back = en;
        i_pipe_write_addr = a;
        i_pipe_write_data = d;
    endtask

    task automatic aux(input logic en, input logic [2:0] a, input logic [15:0] d);
        i_aux_valid = en;
        i_aux_addr  = a;
        i_aux_data  = d;
    endtask

    task automatic test_reset();
        #1 i_reset = 1'b0;
        tick();
        tick();
        total++; if (o_rf_we !== 1'b0)      begin bad++; $display("FAIL reset_we got=%b exp=0", o_rf_we); end
        total++; if (o_rf_addr !== 3'd0)    begin bad++; $display("FAIL reset_addr got=%h exp=0", o_rf_addr); end
        total++; if (o_rf_data !== 16'h0)   begin bad++; $display("FAIL reset_data got=%h exp=0", o_rf_data); end
        total++; if (o_stall !== 1'b0)      begin bad++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
        total++; if (o_aux_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b exp=1", o_aux_ready); end
        total++; if (o_pending !== 8'h00)   begin bad++; $display("FAIL reset_pending got=%h exp=00", o_pending); end
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_pipe_write();
        pipe(1'b1, 3'd3, 16'h1234);
        tick();
        pipe(1'b0, 3'd0, 16'h0);
        total++; if (o_rf_we !== 1'b1)       begin bad++; $display("FAIL pipe_we got=%b exp=1", o_rf_we); end
        total++; if (o_rf_addr !== 3'd3)     begin bad++; $display("FAIL pipe_addr got=%h exp=3", o_rf_addr); end
        total++; if (o_rf_data !== 16'h1234) begin bad++; $display("FAIL pipe_data got=%h exp=1234", o_rf_data); end
        total++; if (o_aux_ready !== 1'b1)   begin bad++; $display("FAIL pipe_ready got=%b exp=1", o_aux_ready); end
        total++; if (o_pending !== 8'h00)    begin bad++; $display("FAIL pipe_pending got=%h exp=00", o_pending); end
        tick();
        total++; if (o_rf_we !== 1'b0)       begin bad++; $display("FAIL pipe_idle_we got=%b exp=0", o_rf_we); end
    endtask

    task automatic test_aux_latency();
        aux(1'b1, 3'd5, 16'hBEEF);
        tick();
        aux(1'b0, 3'd0, 16'h0);
`ifdef WB_ARB_BYPASS_EN
        total++; if (o_rf_we !== 1'b1)       begin bad++; $display("FAIL byp_we got=%b exp=1", o_rf_we); end
        total++; if (o_rf_addr !== 3'd5)     begin bad++; $display("FAIL byp_addr got=%h exp=5", o_rf_addr); end
        total++; if (o_rf_data !== 16'hBEEF) begin bad++; $display("FAIL byp_data got=%h exp=beef", o_rf_data); end
        total++; if (o_pending !== 8'h00)    begin bad++; $display("FAIL byp_pending got=%h exp=00", o_pending); end
        tick();
        total++; if (o_rf_we !== 1'b0)       begin bad++; $display("FAIL byp_after_we got=%b exp=0", o_rf_we); end
`else
        total++; if (o_rf_we !== 1'b0)       begin bad++; $display("FAIL aux_q_we got=%b exp=0", o_rf_we); end
        total++; if (o_pending !== 8'h20)    begin bad++; $display("FAIL aux_q_pending got=%h exp=20", o_pending); end
        tick();
        total++; if (o_rf_we !== 1'b1)       begin bad++; $display("FAIL aux_we got=%b exp=1", o_rf_we); end
        total++; if (o_rf_addr !== 3'd5)     begin bad++; $display("FAIL aux_addr got=%h exp=5", o_rf_addr); end
        total++; if (o_rf_data !== 16'hBEEF) begin bad++; $display("FAIL aux_data got=%h exp=beef", o_rf_data); end
        total++; if (o_pending !== 8'h00)    begin bad++; $display("FAIL aux_pending got=%h exp=00", o_pending); end
        tick();
`endif
    endtask

    task automatic test_fifo_full();
        logic [2:0]  exp_a [3] = '{3'd3, 3'd4, 3'd6};
        logic [15:0] exp_d [3] = '{16'h00A2, 16'h00A3, 16'h00A5};
        for (int k = 0; k < 4; k++) begin
            total++; if (o_aux_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d got=%b exp=1", k, o_aux_ready); end
            pipe(1'b1, 3'd0, 16'h1000 + 16'(k));
            aux(1'b1, 3'(k + 1), 16'h00A0 + 16'(k));
            tick();
        end
        total++; if (o_aux_ready !== 1'b0) begin bad++; $display("FAIL full_ready_drop got=%b exp=0", o_aux_ready); end
        total++; if (o_pending !== 8'h1E)  begin bad++; $display("FAIL full_pending got=%h exp=1e", o_pending); end
        total++; if (o_stall !== 1'b0)     begin bad++; $display("FAIL full_stall_early got=%b exp=0", o_stall); end
        // Fifth offer is held while full; this is also the fourth lost cycle.
        pipe(1'b1, 3'd0, 16'h1004);
        aux(1'b1, 3'd6, 16'h00A5);
        tick();
        total++; if (o_stall !== 1'b1)       begin bad++; $display("FAIL full_stall got=%b exp=1", o_stall); end
        total++; if (o_rf_addr !== 3'd0 || o_rf_data !== 16'h1004) begin bad++; $display("FAIL full_pipe_wr got=%h/%h exp=0/1004", o_rf_addr, o_rf_data); end
        total++; if (o_aux_ready !== 1'b0)   begin bad++; $display("FAIL full_ready_held got=%b exp=0", o_aux_ready); end
        pipe(1'b0, 3'd0, 16'h0);
        tick();
        total++; if (o_rf_we !== 1'b1 || o_rf_addr !== 3'd1 || o_rf_data !== 16'h00A0) begin bad++; $display("FAIL drain_0 got=%b/%h/%h exp=1/1/00a0", o_rf_we, o_rf_addr, o_rf_data); end
        total++; if (o_stall !== 1'b0)       begin bad++; $display("FAIL drain_stall got=%b exp=0", o_stall); end
        total++; if (o_aux_ready !== 1'b1)   begin bad++; $display("FAIL drain_ready got=%b exp=1", o_aux_ready); end
        tick();
        aux(1'b0, 3'd0, 16'h0);
        total++; if (o_rf_we !== 1'b1 || o_rf_addr !== 3'd2 || o_rf_data !== 16'h00A1) begin bad++; $display("FAIL drain_1 got=%b/%h/%h exp=1/2/00a1", o_rf_we, o_rf_addr, o_rf_data); end
        total++; if (o_pending !== 8'h58)    begin bad++; $display("FAIL pushpop_pending got=%h exp=58", o_pending); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (o_rf_we !== 1'b1 || o_rf_addr !== exp_a[k] || o_rf_data !== exp_d[k]) begin bad++; $display("FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", k + 2, o_rf_we, o_rf_addr, o_rf_data, exp_a[k], exp_d[k]); end
        end
        tick();
        total++; if (o_rf_we !== 1'b0)       begin bad++; $display("FAIL drain_done_we got=%b exp=0", o_rf_we); end
        total++; if (o_pending !== 8'h00)    begin bad++; $display("FAIL drain_done_pending got=%h exp=00", o_pending); end
    endtask

    task automatic test_kill();
        pipe(1'b1, 3'd7, 16'h7777);
        aux(1'b1, 3'd2, 16'h0001);
        tick();
        aux(1'b0, 3'd0, 16'h0);
        total++; if (o_pending !== 8'h04)    begin bad++; $display("FAIL kill_pend_set got=%h exp=04", o_pending); end
        pipe(1'b1, 3'd2, 16'h0002);
        tick();
        pipe(1'b0, 3'd0, 16'h0);
        total++; if (o_pending !== 8'h00)    begin bad++; $display("FAIL kill_pend_clr got=%h exp=00", o_pending); end
        total++; if (o_rf_we !== 1'b1 || o_rf_addr !== 3'd2 || o_rf_data !== 16'h0002) begin bad++; $display("FAIL kill_pipe_wr got=%b/%h/%h exp=1/2/0002", o_rf_we, o_rf_addr, o_rf_data); end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (o_rf_we !== 1'b0)   begin bad++; $display("FAIL kill_stale_we_%0d got=%b exp=0", k, o_rf_we); end
        end
    endtask

    task automatic test_same_edge_kill();
        pipe(1'b1, 3'd4, 16'h4444);
        aux(1'b1, 3'd4, 16'h0BAD);
        tick();
        pipe(1'b0, 3'd0, 16'h0);
        aux(1'b0, 3'd0, 16'h0);
        total++; if (o_pending !== 8'h00)    begin bad++; $display("FAIL same_kill_pend got=%h exp=00", o_pending); end
        total++; if (o_rf_data !== 16'h4444) begin bad++; $display("FAIL same_kill_pipe got=%h exp=4444", o_rf_data); end
        tick();
        total++; if (o_rf_we !== 1'b0)       begin bad++; $display("FAIL same_kill_pop_we got=%b exp=0", o_rf_we); end
        tick();
        total++; if (o_rf_we !== 1'b0)       begin bad++; $display("FAIL same_kill_idle_we got=%b exp=0", o_rf_we); end
    endtask

    task automatic test_starvation();
        aux(1'b1, 3'd5, 16'h5555);
        for (int k = 0; k < 4; k++) begin
            pipe(1'b1, 3'd0, 16'h2000 + 16'(k));
            tick();
            aux(1'b0, 3'd0, 16'h0);
            total++; if (o_stall !== 1'b0)   begin bad++; $display("FAIL starve_early_%0d got=%b exp=0", k, o_stall); end
        end
        pipe(1'b1, 3'd0, 16'h2004);
        tick();
        total++; if (o_stall !== 1'b1)       begin bad++; $display("FAIL starve_rise got=%b exp=1", o_stall); end
        // Pipe ignores the stall once: it still wins and the stall holds.
        pipe(1'b1, 3'd0, 16'h2005);
        tick();
        total++; if (o_stall !== 1'b1 || o_rf_data !== 16'h2005) begin bad++; $display("FAIL starve_sat got=%b/%h exp=1/2005", o_stall, o_rf_data); end
        pipe(1'b0, 3'd0, 16'h0);
        tick();
        total++; if (o_rf_we !== 1'b1 || o_rf_addr !== 3'd5 || o_rf_data !== 16'h5555) begin bad++; $display("FAIL starve_head got=%b/%h/%h exp=1/5/5555", o_rf_we, o_rf_addr, o_rf_data); end
        total++; if (o_stall !== 1'b0)       begin bad++; $display("FAIL starve_clear got=%b exp=0", o_stall); end
        tick();
        total++; if (o_rf_we !== 1'b0)       begin bad++; $display("FAIL starve_idle got=%b exp=0", o_rf_we); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            pipe(1'b1, 3'd0, 16'h3000 + 16'(k));
            if (k < 3) aux(1'b1, 3'(k + 1), 16'h00C1 + 16'(k));
            else       aux(1'b0, 3'd0, 16'h0);
            tick();
        end
        aux(1'b0, 3'd0, 16'h0);
        total++; if (o_stall !== 1'b1)       begin bad++; $display("FAIL rmid_stall_pre got=%b exp=1", o_stall); end
        total++; if (o_pending !== 8'h0E)    begin bad++; $display("FAIL rmid_pend_pre got=%h exp=0e", o_pending); end
        pipe(1'b0, 3'd0, 16'h0);
        i_reset = 1'b0;
        #2;
        total++; if (o_rf_we !== 1'b0 || o_rf_addr !== 3'd0 || o_rf_data !== 16'h0) begin bad++; $display("FAIL rmid_rf got=%b/%h/%h exp=0/0/0", o_rf_we, o_rf_addr, o_rf_data); end
        total++; if (o_stall !== 1'b0)       begin bad++; $display("FAIL rmid_stall got=%b exp=0", o_stall); end
        total++; if (o_aux_ready !== 1'b1)   begin bad++; $display("FAIL rmid_ready got=%b exp=1", o_aux_ready); end
        total++; if (o_pending !== 8'h00)    begin bad++; $display("FAIL rmid_pending got=%h exp=00", o_pending); end
        tick();
        i_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (o_rf_we !== 1'b0 || o_stall !== 1'b0) begin bad++; $display("FAIL rmid_post_%0d we/stall got=%b/%b exp=0/0", k, o_rf_we, o_stall); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_aux_latency();
        test_fifo_full();
        test_kill();
        test_same_edge_kill();
        test_starvation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the pipeline's write-back stage and a long-latency auxiliary unit, such as a multi-cycle multiplier/divider or a slow memory return path. Pipeline writes always win. Auxiliary results are buffered in a small FIFO and drained into idle write-back slots. Queued results made stale by a younger pipeline write to the same register are killed. A starvation counter forces a pipeline bubble so the auxiliary unit cannot be locked out forever.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 registers)
- FIFO_DEPTH, 4, auxiliary queue entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive lost cycles before a stall is forced (1..15)

Ports:
- i_clk  input  1  clock; all state on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_pipe_write_back  input  1  pipeline write request this cycle
- i_pipe_write_addr  input  ADDR_W  pipeline destination register
- i_pipe_write_data  input  DATA_W  pipeline write data
- i_aux_valid  input  1  auxiliary result offered
- o_aux_ready  output  1  auxiliary result accepted when high with i_aux_valid
- i_aux_addr  input  ADDR_W  auxiliary destination register
- i_aux_data  input  DATA_W  auxiliary result
- o_rf_we  output  1  register-file write enable (registered)
- o_rf_addr  output  ADDR_W  register-file write address (registered)
- o_rf_data  output  DATA_W  register-file write data (registered)
- o_stall  output  1  registered; pipeline must present no write while high
- o_pending  output  2**ADDR_W  one bit per register holding a live queued aux entry, for hazard detection

## Operation
- Each edge selects at most one write source, in this priority order:
  1. Pipeline, when i_pipe_write_back is high.
  2. FIFO head.
  3. Bypassed aux input (only with the macro defined).
- The selected write is registered into o_rf_*. If nothing is selected, o_rf_we is 0.
- FIFO entries hold {live, addr, data}. A head entry that is not live is popped with o_rf_we=0; this consumes the slot.
- Kill rule: an accepted pipe write to address X clears live on every FIFO entry with addr X, in the same edge.
  - An aux input accepted on that same edge with addr X is enqueued not-live, or dropped if bypassed.
  - By contract, aux results are always older than any concurrent pipe write.
- o_aux_ready = !full, using the registered count. There is no pass-through when full.
- A simultaneous pop and push keeps the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Starvation counter behaviour:
  - Increments on each edge where the FIFO head is live and the pipe wins the port.
  - Clears to 0 on any edge where the head is written, or the FIFO is empty.
- At count == STARVE_LIMIT, o_stall is set on that edge. It stays high until the head live entry is written, then clears on the same edge as that write.
- If the pipe writes while o_stall is high (a protocol violation), the pipe still wins and the counter saturates at its limit.
- o_pending is combinational, built from the live bits and addresses of the FIFO entries.

## Timing
- Reset (i_reset low, asynchronous) clears:
  - o_rf_we, o_rf_addr, o_rf_data, o_stall and the starvation count, all to 0.
  - FIFO count and pointers, all to 0; all live bits to 0.
  - Results after reset: o_aux_ready=1 and o_pending=0.
- Reset mid-operation discards all queued entries. No write is issued for them.
- Pipe latency: request in cycle N appears on o_rf_* in cycle N+1.
- Aux latency when the FIFO is empty and the pipe is idle:
  - With bypass: 1 cycle.
  - Without bypass: 2 cycles (enqueue edge, then pop edge).
- With the pipe continuously busy, o_stall rises STARVE_LIMIT cycles after the first lost cycle. The head is written on the first edge at which o_stall is high.

## Configuration
- WB_ARB_BYPASS_EN defined: when the FIFO is empty, the pipe is idle and i_aux_valid is high, the aux input is written directly to o_rf_* and not enqueued.
- WB_ARB_BYPASS_EN undefined: every aux result passes through the FIFO.

## Structure
- Package wb_arb_pkg:
  - Entry typedef {live, addr, data}.
  - Default width and depth constants.
  - Select encoding: NONE, PIPE, FIFO, BYPASS.
- Sub-module wb_arb_fifo: circular buffer providing push, pop, kill-by-address, the live mask and full/empty.
- The top level holds the select logic, the starvation counter and the output registers.

## Test plan
- Reset, then pipe write r3=0x1234 -> o_rf_we=1, addr=3, data=0x1234 one cycle later. o_aux_ready=1 and o_pending=0 throughout.
- Pipe idle, aux r5=0xBEEF -> with bypass, written next cycle; without bypass, written 2 cycles later with o_pending[5] high for 1 cycle.
- Pipe busy, 4 aux pushes -> o_aux_ready drops after the 4th push. A 5th offer is held until a pop. The FIFO drains in order once the pipe idles.
- Aux r2=0x0001 queued, then pipe write r2=0x0002 -> o_pending[2] clears. The queued entry pops with o_rf_we=0. Final r2 write = 0x0002 only.
- Pipe busy continuously with a live head, STARVE_LIMIT=4 -> o_stall rises after 4 lost cycles. The head is written while the pipe bubbles, then o_stall clears.
- Assert i_reset with 3 entries queued and o_stall high -> all outputs go to 0 immediately, o_aux_ready=1, and no stale writes follow release.
